alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter MCP_CYCLES, default 2: extra ALU cycles granted when the ALU flags a multi-cycle op; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  request handshake; transfer when both are high on a rising edge.
REQ-005 req_opcode, req_a, req_b  input  6, 32, 32  opcode from the shared opcode header, and operands A and B.
REQ-006 alu_din_a, alu_din_b, alu_opcode, alu_cin, alu_vin  output  32, 32, 6, 1, 1  drive to the ALU.
REQ-007 alu_dout, alu_cout, alu_vout, alu_qnz, alu_mcp  input  32, 1, 1, 1, 1  ALU result and status.
REQ-008 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-009 rsp_data, rsp_c, rsp_v, rsp_qnz, rsp_wen  output  32, 1, 1, 1, 1  captured result and flags; rsp_wen indicates a register writeback is required.
REQ-010 flag_wr, flag_c, flag_v  input  1, 1, 1  direct write of the C and V flags.
REQ-011 flush  input  1  synchronous abort of any operation in flight.
REQ-012 c_flag, v_flag, busy  output  1, 1, 1  architectural flags and a not-IDLE indicator.

Function
REQ-013 FSM states: IDLE, EXEC, WAIT, DONE; req_ready=1 only in IDLE; busy=1 in every state except IDLE.
REQ-014 IDLE: on a request transfer, register the opcode and both operands, then go to EXEC.
REQ-015 ALU drive: alu_din_a, alu_din_b and alu_opcode come from the operand registers; alu_cin=c_flag; alu_vin=v_flag; all are held stable in EXEC and WAIT.
REQ-016 EXEC, alu_mcp=0 or macro absent: capture alu_dout/cout/vout/qnz into the rsp_* registers and c_flag/v_flag, then go to DONE.
REQ-017 EXEC, alu_mcp=1 with macro present: load the wait counter with MCP_CYCLES, capture nothing, and go to WAIT.
REQ-018 WAIT: decrement the counter each cycle; in the cycle the counter equals 1, capture as in REQ-016 and go to DONE.
REQ-019 Latency: rsp_valid rises 2 edges after the accept edge, or 2+MCP_CYCLES edges for a multi-cycle op.
REQ-020 DONE: rsp_valid=1; rsp_* are held stable until rsp_valid&&rsp_ready, then go to IDLE; there is no same-cycle re-accept, so throughput is at most 1 op per 3 cycles.
REQ-021 rsp_wen=0 when the opcode is CMP or BTST; otherwise 1.
REQ-022 rsp_qnz reflects alu_qnz as captured; it is meaningful only for DJNZ.
REQ-023 flag_wr=1: c_flag<=flag_c and v_flag<=flag_v in any state; on the same edge as a capture, flag_wr wins for the flags; rsp_c and rsp_v still take the ALU values.
REQ-024 flush=1: next state IDLE from any state; the pending response is dropped; no flag capture occurs on that edge; flag_wr is still honoured.
REQ-025 flush has priority over a request transfer and over a response transfer on the same edge.
REQ-026 rsp_ready held low: the block stays in DONE indefinitely with no data change.

Reset
REQ-027 reset_b low forces, asynchronously: state=IDLE, counter=0, c_flag=0, v_flag=0, rsp_valid=0, rsp_data=0, rsp_c=0, rsp_v=0, rsp_qnz=0, rsp_wen=0, operand registers=0.
REQ-028 Reset asserted mid-operation abandons the operation; the first cycle after release is IDLE with req_ready=1.

Configuration
REQ-029 Macro ALU_MCP_WAIT_EN defined: alu_mcp is honoured per REQ-017/018, and the WAIT state and counter exist.
REQ-030 Macro absent: alu_mcp is ignored, every op takes the REQ-016 path, and the WAIT state and counter are not synthesised.

Verification
REQ-031 ADD with A=0x7FFFFFFF, B=1, c=0 -> rsp_valid 2 edges after accept; rsp_data=0x80000000, rsp_v=1, rsp_c=0, rsp_wen=1; v_flag=1.
REQ-032 CMP with A=5, B=5 -> rsp_data=0, rsp_wen=0, rsp_c=0.
REQ-033 Macro present, MCP_CYCLES=2, alu_mcp=1 in EXEC -> rsp_valid exactly 4 edges after accept; ALU inputs stable throughout.
REQ-034 rsp_ready=0 for 5 cycles in DONE -> rsp_* unchanged and req_ready=0; the response transfers on the 6th cycle and req_ready=1 the next cycle.
REQ-035 flush in WAIT -> IDLE next cycle, rsp_valid never asserted, c_flag/v_flag unchanged.
REQ-036 reset_b pulsed low in EXEC -> immediate IDLE with all REQ-027 values; flag_wr coincident with capture (flag_c=1, ALU cout=0) -> c_flag=1, rsp_c=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op at a time to an external ALU and holds the response until taken.
// Define ALU_MCP_WAIT_EN to honour alu_mcp with a WAIT state of MCP_CYCLES extra cycles.
module alu_issue_ctrl #(
  parameter int MCP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_din_a,
  output logic [31:0] alu_din_b,
  output logic [5:0]  alu_opcode,
  output logic        alu_cin,
  output logic        alu_vin,
  input  logic [31:0] alu_dout,
  input  logic        alu_cout,
  input  logic        alu_vout,
  input  logic        alu_qnz,
  input  logic        alu_mcp,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_qnz,
  output logic        rsp_wen,
  input  logic        flag_wr,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic        flush,
  output logic        c_flag,
  output logic        v_flag,
  output logic        busy
);
  localparam logic [5:0] OP_CMP = 6'h05, OP_BTST = 6'h0A;
`ifdef ALU_MCP_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2, WAIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`endif
  state_t state, nxt;
  logic cap, accept;
`ifdef ALU_MCP_WAIT_EN
  logic [3:0] cnt;
`else
  logic [4:0] unused_cfg;
  assign unused_cfg = {alu_mcp, 4'(MCP_CYCLES)};
`endif
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign rsp_valid = state == DONE;
  assign alu_cin   = c_flag;
  assign alu_vin   = v_flag;
  assign accept    = req_ready && req_valid && !flush;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    cap = 1'b0;
    case (state)
      IDLE: nxt = req_valid ? EXEC : IDLE;
`ifdef ALU_MCP_WAIT_EN
      EXEC: begin
        nxt = alu_mcp ? WAIT : DONE;
        cap = !alu_mcp;
      end
      WAIT: begin
        nxt = (cnt == 4'd1) ? DONE : WAIT;
        cap = cnt == 4'd1;
      end
`else
      EXEC: begin
        nxt = DONE;
        cap = 1'b1;
      end
`endif
      DONE: nxt = rsp_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    if (flush) begin
      nxt = IDLE;
      cap = 1'b0;
    end
  end
`ifdef ALU_MCP_WAIT_EN
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) cnt <= '0;
    else if (flush) cnt <= '0;
    else if (state == EXEC && alu_mcp) cnt <= 4'(MCP_CYCLES);
    else if (state == WAIT) cnt <= cnt - 4'd1;
`endif
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      alu_opcode <= '0;
      alu_din_a  <= '0;
      alu_din_b  <= '0;
    end else if (accept) begin
      alu_opcode <= req_opcode;
      alu_din_a  <= req_a;
      alu_din_b  <= req_b;
    end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      rsp_data <= '0;
      rsp_c    <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_qnz  <= 1'b0;
      rsp_wen  <= 1'b0;
    end else if (cap) begin
      rsp_data <= alu_dout;
      rsp_c    <= alu_cout;
      rsp_v    <= alu_vout;
      rsp_qnz  <= alu_qnz;
      rsp_wen  <= !(alu_opcode == OP_CMP || alu_opcode == OP_BTST);
    end
  // A direct flag write overrides the ALU result landing on the same edge.
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) {c_flag, v_flag} <= 2'b00;
    else if (flag_wr) {c_flag, v_flag} <= {flag_c, flag_v};
    else if (cap) {c_flag, v_flag} <= {alu_cout, alu_vout};
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a transaction-level model and a per-cycle compare.
module tb_alu_issue_ctrl;
  localparam int MCP = 2;
  localparam logic [5:0] OP_ADD = 6'h01, OP_CMP = 6'h05, OP_BTST = 6'h0A, OP_DJNZ = 6'h10;
  logic clk, reset_b, req_valid, req_ready, alu_cin, alu_vin, alu_cout, alu_vout, alu_qnz, tb_mcp;
  logic rsp_valid, rsp_ready, rsp_c, rsp_v, rsp_qnz, rsp_wen, flag_wr, flag_c, flag_v, flush;
  logic c_flag, v_flag, busy;
  logic [5:0] req_opcode, alu_opcode;
  logic [31:0] req_a, req_b, alu_din_a, alu_din_b, alu_dout, rsp_data;
  int n_tests = 0, n_fail = 0, lat;

  alu_issue_ctrl #(.MCP_CYCLES(MCP)) dut (
    .clk(clk), .reset_b(reset_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_din_a(alu_din_a), .alu_din_b(alu_din_b), .alu_opcode(alu_opcode),
    .alu_cin(alu_cin), .alu_vin(alu_vin), .alu_dout(alu_dout), .alu_cout(alu_cout),
    .alu_vout(alu_vout), .alu_qnz(alu_qnz), .alu_mcp(tb_mcp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_c(rsp_c),
    .rsp_v(rsp_v), .rsp_qnz(rsp_qnz), .rsp_wen(rsp_wen),
    .flag_wr(flag_wr), .flag_c(flag_c), .flag_v(flag_v), .flush(flush),
    .c_flag(c_flag), .v_flag(v_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {qnz, v, c, result}.
  function automatic logic [34:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v, q;
    s = '0; r = '0; c = 1'b0; v = 1'b0; q = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_CMP: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_BTST: r = a & (32'd1 << b[4:0]);
      OP_DJNZ: begin r = a - 32'd1; q = r != 32'd0; end
      default: r = a ^ b;
    endcase
    return {q, v, c, r};
  endfunction

  assign {alu_qnz, alu_vout, alu_cout, alu_dout} = alu_fn(alu_opcode, alu_din_a, alu_din_b, alu_cin);

  // Transaction model: an op in flight ages one per edge and completes at age m_lat.
  logic m_pend, m_done, n_pend, n_done, m_rc, m_rv, m_rq, m_rw, n_rc, n_rv, n_rq, n_rw;
  logic m_c, m_v, n_c, n_v, cap;
  int m_age, m_lat, n_age, n_lat;
  logic [5:0] m_op, n_op;
  logic [31:0] m_a, m_b, m_data, n_a, n_b, n_data;
  logic [34:0] res;
  always_comb begin
    n_pend = m_pend; n_done = m_done; n_age = m_age; n_lat = m_lat;
    n_op = m_op; n_a = m_a; n_b = m_b; n_data = m_data;
    n_rc = m_rc; n_rv = m_rv; n_rq = m_rq; n_rw = m_rw; n_c = m_c; n_v = m_v;
    cap = 1'b0;
    res = alu_fn(m_op, m_a, m_b, m_c);
    if (flush) begin
      n_pend = 1'b0; n_done = 1'b0;
    end else if (m_pend) begin
      n_age = m_age + 1;
`ifdef ALU_MCP_WAIT_EN
      if (n_age == 1 && tb_mcp) n_lat = 1 + MCP;
`endif
      if (n_age == n_lat) begin
        cap = 1'b1; n_pend = 1'b0; n_done = 1'b1;
        {n_rq, n_rv, n_rc, n_data} = res;
        n_rw = m_op != OP_CMP && m_op != OP_BTST;
      end
    end else if (m_done) n_done = !rsp_ready;
    else if (req_valid) begin
      n_pend = 1'b1; n_age = 0; n_lat = 1; n_op = req_opcode; n_a = req_a; n_b = req_b;
    end
    if (flag_wr) begin n_c = flag_c; n_v = flag_v; end
    else if (cap) begin n_c = res[32]; n_v = res[33]; end
  end
  always @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      m_pend <= 1'b0; m_done <= 1'b0; m_age <= 0; m_lat <= 1; m_op <= '0; m_a <= '0; m_b <= '0;
      m_data <= '0; m_rc <= 1'b0; m_rv <= 1'b0; m_rq <= 1'b0; m_rw <= 1'b0; m_c <= 1'b0; m_v <= 1'b0;
    end else begin
      m_pend <= n_pend; m_done <= n_done; m_age <= n_age; m_lat <= n_lat; m_op <= n_op;
      m_a <= n_a; m_b <= n_b; m_data <= n_data; m_rc <= n_rc; m_rv <= n_rv; m_rq <= n_rq;
      m_rw <= n_rw; m_c <= n_c; m_v <= n_v;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (reset_b) begin
    chk("req_ready", 32'(req_ready), 32'(!m_pend && !m_done));
    chk("busy", 32'(busy), 32'(m_pend || m_done));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_done));
    chk("c_flag", 32'(c_flag), 32'(m_c));
    chk("v_flag", 32'(v_flag), 32'(m_v));
    if (m_done) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_c", 32'(rsp_c), 32'(m_rc));
      chk("rsp_v", 32'(rsp_v), 32'(m_rv));
      chk("rsp_qnz", 32'(rsp_qnz), 32'(m_rq));
      chk("rsp_wen", 32'(rsp_wen), 32'(m_rw));
    end
    if (m_pend) begin
      chk("alu_din_a", alu_din_a, m_a);
      chk("alu_din_b", alu_din_b, m_b);
      chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
      chk("alu_cin", 32'(alu_cin), 32'(m_c));
      chk("alu_vin", 32'(alu_vin), 32'(m_v));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    while (!req_ready && k < 20) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge (as 1) to the edge raising rsp_valid.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 40) begin tick(); flag_wr = 1'b0; l++; end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic fwrite(input logic c, input logic v);
    flag_wr = 1'b1; flag_c = c; flag_v = v;
    tick();
    flag_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; tb_mcp = 1'b0;
    rsp_ready = 1'b0; flag_wr = 1'b0; flag_c = 1'b0; flag_v = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst rsp_wen", 32'(rsp_wen), 32'd0);
    chk("rst flags", 32'({c_flag, v_flag}), 32'd0);
    reset_b = 1'b1;
    tick();
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    wait_rsp(lat);
    chk("add latency", 32'(lat), 32'd2);
    chk("add data", rsp_data, 32'h8000_0000);
    chk("add rsp_v", 32'(rsp_v), 32'd1);
    chk("add rsp_c", 32'(rsp_c), 32'd0);
    chk("add rsp_wen", 32'(rsp_wen), 32'd1);
    chk("add v_flag", 32'(v_flag), 32'd1);
    take();
    send(OP_CMP, 32'd5, 32'd5);
    wait_rsp(lat);
    chk("cmp latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      chk("cmp data", rsp_data, 32'd0);
      chk("cmp rsp_wen", 32'(rsp_wen), 32'd0);
      chk("cmp rsp_c", 32'(rsp_c), 32'd0);
      tick();
    end
    take();
    chk("bp req_ready after", 32'(req_ready), 32'd1);
    chk("bp rsp_valid after", 32'(rsp_valid), 32'd0);
    send(OP_BTST, 32'h10, 32'd4);
    wait_rsp(lat);
    chk("btst data", rsp_data, 32'h10);
    chk("btst rsp_wen", 32'(rsp_wen), 32'd0);
    take();
    send(OP_DJNZ, 32'd1, 32'd0);
    wait_rsp(lat);
    chk("djnz1 data", rsp_data, 32'd0);
    chk("djnz1 qnz", 32'(rsp_qnz), 32'd0);
    take();
    send(OP_DJNZ, 32'd5, 32'd0);
    wait_rsp(lat);
    chk("djnz5 data", rsp_data, 32'd4);
    chk("djnz5 qnz", 32'(rsp_qnz), 32'd1);
    take();
    fwrite(1'b1, 1'b0);
    chk("flag_wr c", 32'(c_flag), 32'd1);
    send(OP_ADD, 32'hFFFF_FFFF, 32'd0);
    wait_rsp(lat);
    chk("addc data", rsp_data, 32'd0);
    chk("addc rsp_c", 32'(rsp_c), 32'd1);
    take();
    send(OP_ADD, 32'd1, 32'd1);
    wait_rsp(lat);
    chk("addc2 data", rsp_data, 32'd3);
    take();
    chk("addc2 c_flag", 32'(c_flag), 32'd0);
    send(OP_ADD, 32'd1, 32'd2);
    flag_wr = 1'b1; flag_c = 1'b1; flag_v = 1'b0;
    wait_rsp(lat);
    chk("coinc c_flag", 32'(c_flag), 32'd1);
    chk("coinc rsp_c", 32'(rsp_c), 32'd0);
    chk("coinc data", rsp_data, 32'd3);
    take();
    send(OP_BTST, 32'd1, 32'd0);
    wait_rsp(lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush done rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush done req_ready", 32'(req_ready), 32'd1);
    send(OP_ADD, 32'h8000_0000, 32'h8000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush exec req_ready", 32'(req_ready), 32'd1);
    chk("flush exec flags", 32'({c_flag, v_flag}), 32'd0);
    tick(); tick();
    chk("flush exec no rsp", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush beats req", 32'(busy), 32'd0);
`ifdef ALU_MCP_WAIT_EN
    tb_mcp = 1'b1;
    send(OP_ADD, 32'd10, 32'd20);
    wait_rsp(lat);
    tb_mcp = 1'b0;
    chk("mcp latency", 32'(lat), 32'd4);
    chk("mcp data", rsp_data, 32'd30);
    take();
    tb_mcp = 1'b1;
    send(OP_ADD, 32'h8000_0000, 32'h8000_0000);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; tb_mcp = 1'b0;
    chk("flush wait req_ready", 32'(req_ready), 32'd1);
    chk("flush wait flags", 32'({c_flag, v_flag}), 32'd0);
    tick(); tick(); tick();
    chk("flush wait no rsp", 32'(rsp_valid), 32'd0);
`endif
    fwrite(1'b1, 1'b1);
    send(OP_ADD, 32'd1, 32'd1);
    #2 reset_b = 1'b0;
    #1;
    chk("arst req_ready", 32'(req_ready), 32'd1);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst flags", 32'({c_flag, v_flag}), 32'd0);
    chk("arst rsp_data", rsp_data, 32'd0);
    chk("arst din_a", alu_din_a, 32'd0);
    tick();
    reset_b = 1'b1;
    tick();
    chk("post rst req_ready", 32'(req_ready), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
